// File: rtl/sd_sector_server_pkg.sv
// Shared types and constants for the SD sector server: FSM state encoding,
// sector geometry and small address / range helpers.
package sd_sector_server_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_MEM  = 3'd1,
    ST_RD_PUT  = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_CAP  = 3'd4,
    ST_WR_MEM  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam int SECTOR_WORDS = 256;
  localparam int SECTOR_SHIFT = 9;

  // Word address of word idx of sector lba; the 24-bit sum wraps by design.
  function automatic logic [23:0] word_addr(input logic [23:0] base,
                                            input logic [15:0] lba,
                                            input logic [7:0]  idx);
    return base + {lba, idx};
  endfunction

  // A zero-sized image counts as unmounted, so every sector is out of range.
  function automatic logic out_of_range(input logic [31:0] lba,
                                        input logic [63:0] size);
    logic [63:0] byte_off;
    byte_off = {32'h0, lba} << SECTOR_SHIFT;
    return (size == 64'h0) || (byte_off >= size);
  endfunction

endpackage

// File: rtl/sd_sector_server.sv
// Serves 512-byte SD sectors from a word-addressed backing memory: reads copy
// memory into the core's sector buffer, writes copy the buffer into memory.
module sd_sector_server
  import sd_sector_server_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = 24'h000000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        mount_req,
  input  logic [63:0] mount_size,
  input  logic        mount_ro,
  output logic        img_mounted,
  output logic [63:0] img_size,
  output logic        img_readonly,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [15:0] sd_buff_din,
  output logic [23:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  input  logic        mem_ack,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: sd_rd/sd_wr are levels sampled only in IDLE while sd_ack is
  // low; sd_ack then stays high until DONE. mem_rd/mem_wr are held with a
  // stable mem_addr/mem_din until a one-cycle mem_ack, and drop the next cycle.

  state_e      state_q;
  logic [15:0] lba_q;
  logic [7:0]  idx_q;
  logic        skip_q;
  logic        ro_q;
  logic        sd_ack_q;
  logic [7:0]  sd_buff_addr_q;
  logic [15:0] sd_buff_dout_q;
  logic        sd_buff_wr_q;
  logic [23:0] mem_addr_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [15:0] mem_din_q;
  logic        img_mounted_q;
  logic [63:0] img_size_q;
  logic        img_ro_q;

  logic [7:0]  idx_d;
  logic        start_skip;
  logic        last_word;

  assign idx_d      = idx_q + 8'd1;
  assign last_word  = (idx_q == 8'(SECTOR_WORDS - 1));
  assign start_skip = out_of_range(sd_lba, img_size_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      lba_q          <= 16'h0;
      idx_q          <= 8'h0;
      skip_q         <= 1'b0;
      ro_q           <= 1'b0;
      sd_ack_q       <= 1'b0;
      sd_buff_addr_q <= 8'h0;
      sd_buff_dout_q <= 16'h0;
      sd_buff_wr_q   <= 1'b0;
      mem_addr_q     <= 24'h0;
      mem_rd_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      mem_din_q      <= 16'h0;
      img_mounted_q  <= 1'b0;
      img_size_q     <= 64'h0;
      img_ro_q       <= 1'b0;
    end else begin
      // Mount info updates immediately; a running transfer keeps its snapshot.
      img_mounted_q <= mount_req;
      if (mount_req) begin
        img_size_q <= mount_size;
        img_ro_q   <= mount_ro;
      end
      sd_buff_wr_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (!sd_ack_q && (sd_rd || sd_wr)) begin
            lba_q          <= sd_lba[15:0];
            skip_q         <= start_skip;
            ro_q           <= img_ro_q;
            idx_q          <= 8'h0;
            sd_ack_q       <= 1'b1;
            sd_buff_addr_q <= 8'h0;
            mem_addr_q     <= word_addr(BASE_ADDR, sd_lba[15:0], 8'h0);
            if (sd_rd) begin
              mem_rd_q <= !start_skip;
              state_q  <= ST_RD_MEM;
            end else begin
              state_q  <= ST_WR_ADDR;
            end
          end
        end

        ST_RD_MEM: begin
          if (skip_q || mem_ack) begin
            mem_rd_q       <= 1'b0;
            sd_buff_dout_q <= skip_q ? 16'h0000 : mem_dout;
            sd_buff_addr_q <= idx_q;
            sd_buff_wr_q   <= 1'b1;
            state_q        <= ST_RD_PUT;
          end
        end

        ST_RD_PUT: begin
          idx_q <= idx_d;
          if (last_word) begin
            sd_ack_q <= 1'b0;
            state_q  <= ST_DONE;
          end else begin
            mem_addr_q <= word_addr(BASE_ADDR, lba_q, idx_d);
            mem_rd_q   <= !skip_q;
            state_q    <= ST_RD_MEM;
          end
        end

        ST_WR_ADDR: begin
          sd_buff_addr_q <= idx_q;
          state_q        <= ST_WR_CAP;
        end

        // The core buffer answers one cycle after the address moves.
        ST_WR_CAP: begin
          mem_din_q  <= sd_buff_din;
          mem_addr_q <= word_addr(BASE_ADDR, lba_q, idx_q);
          mem_wr_q   <= !(skip_q || ro_q);
          state_q    <= ST_WR_MEM;
        end

        ST_WR_MEM: begin
          if (skip_q || ro_q || mem_ack) begin
            mem_wr_q <= 1'b0;
            idx_q    <= idx_d;
            if (last_word) begin
              sd_ack_q <= 1'b0;
              state_q  <= ST_DONE;
            end else begin
              sd_buff_addr_q <= idx_d;
              state_q        <= ST_WR_ADDR;
            end
          end
        end

        ST_DONE: begin
          sd_buff_addr_q <= 8'h0;
          idx_q          <= 8'h0;
          state_q        <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign img_mounted  = img_mounted_q;
  assign img_size     = img_size_q;
  assign img_readonly = img_ro_q;
  assign sd_ack       = sd_ack_q;
  assign sd_buff_addr = sd_buff_addr_q;
  assign sd_buff_dout = sd_buff_dout_q;
  assign sd_buff_wr   = sd_buff_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_din      = mem_din_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/sd_sector_server.md
SD_SECTOR_SERVER -- requirements
Module: sd_sector_server

Interface
REQ-001 Parameter BASE_ADDR, default 24'h000000, word address in backing memory where the image starts.
REQ-002 clk_sys  input  1  single clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mount_req  input  1  one-cycle pulse requesting image (re)mount; mount_size and mount_ro sampled on the same cycle.
REQ-005 mount_size  input  64  image size in bytes. mount_ro  input  1  image is read-only.
REQ-006 img_mounted  output  1  one-cycle mount pulse. img_size  output  64  latched image size. img_readonly  output  1  latched read-only flag.
REQ-007 sd_lba  input  32  sector number. sd_rd  input  1  read request, level. sd_wr  input  1  write request, level.
REQ-008 sd_ack  output  1  transfer in progress. sd_buff_addr  output  8  word index 0..255.
REQ-009 sd_buff_dout  output  16  read data to core. sd_buff_wr  output  1  write strobe to core buffer.
REQ-010 sd_buff_din  input  16  core buffer data; valid one cycle after sd_buff_addr changes.
REQ-011 mem_addr  output  24  word address. mem_rd  output  1  read request. mem_wr  output  1  write request. mem_din  output  16  write data.
REQ-012 mem_dout  input  16  read data. mem_ack  input  1  one-cycle completion pulse; mem_dout valid with it.

Function
REQ-013 FSM states: IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_CAP, WR_MEM, DONE.
REQ-014 IDLE: with sd_ack low and sd_rd=1, latch sd_lba, raise sd_ack next cycle, enter RD_MEM; with sd_wr=1 (and sd_rd=0), same but enter WR_ADDR.
REQ-015 sd_rd and sd_wr high together: read wins; the write is ignored.
REQ-016 Each sector is 256 words; word i maps to mem_addr = BASE_ADDR + lba[15:0]*256 + i, truncated to 24 bits.
REQ-017 RD_MEM: hold mem_rd and mem_addr until mem_ack, capture mem_dout, then go to RD_PUT.
REQ-018 RD_PUT: drive sd_buff_addr=i and sd_buff_dout, pulse sd_buff_wr for exactly one cycle, increment i; i=255 goes to DONE, else RD_MEM.
REQ-019 WR_ADDR: drive sd_buff_addr=i, go to WR_CAP. WR_CAP: capture sd_buff_din, go to WR_MEM.
REQ-020 WR_MEM: hold mem_wr, mem_addr and mem_din until mem_ack; then i=255 goes to DONE, else increment i and go to WR_ADDR.
REQ-021 Out of range (lba*512 >= img_size, or no image mounted): on read, skip memory and return 16'h0000 words; on write, skip memory and drop the data. Handshake timing is otherwise unchanged.
REQ-022 Write with img_readonly=1: the full handshake completes; no mem_wr is issued.
REQ-023 DONE: drop sd_ack, drive sd_buff_addr=0, return to IDLE.
REQ-024 At least one cycle of sd_ack low separates transfers; a request still high in IDLE starts a new transfer.
REQ-025 sd_ack stays high continuously from its rise until DONE.
REQ-026 sd_buff_wr is asserted only while sd_ack=1.
REQ-027 mem_rd and mem_wr are never both high, and each deasserts the cycle after mem_ack.
REQ-028 mount_req: latch img_size and img_readonly, pulse img_mounted one cycle later.
REQ-029 mount_req during a transfer: latch the new values immediately; range checks for the current sector use the values held at transfer start.
REQ-030 A mount_size of 0 marks the image unmounted.

Reset
REQ-031 On reset_n low, asynchronously: state=IDLE, sd_ack=0, sd_buff_wr=0, sd_buff_addr=0, sd_buff_dout=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_din=0, img_mounted=0, img_size=0, img_readonly=0, i=0.
REQ-032 Reset mid-transfer aborts the transfer; any outstanding mem_ack arriving after reset is ignored.

Structure
REQ-033 A shared package holds the FSM state enum, SECTOR_WORDS=256, and the byte-per-sector shift of 9.
REQ-034 The design is one flat module; no sub-module.

Verification
REQ-035 Mount 64'd8192 RW, sd_rd with lba=3, memory holds word=address -> 256 sd_buff_wr pulses; addr 0..255 carries data BASE+768+i; sd_ack falls after the last pulse.
REQ-036 sd_wr with lba=1, core buffer holds 16'hA500+i -> mem_wr at BASE+256+i with that data; the DONE state is reached; exactly 256 mem_wr handshakes occur.
REQ-037 sd_rd with lba=16 on an 8192-byte image -> 256 zero words and no mem_rd.
REQ-038 Same write with mount_ro=1 -> no mem_wr, and sd_ack still completes the full sequence.
REQ-039 sd_rd and sd_wr asserted in the same cycle -> read transfer only; a mem_ack delay of 5 cycles stretches the transfer with no extra strobes.
REQ-040 reset_n pulled low at word 100 of a read -> all outputs return to reset values; a new read afterwards completes with all 256 words correct.
